// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with single-cycle arithmetic, logic and compare
// ops, plus an iterative multiply/divide unit that writes HI/LO in the background.
// The pipeline controller holds ID/EX via stall while the unit is busy.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       aluctr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             wrctr,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_SLL   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_ADDU  = 4'b0101;
   localparam logic [3:0] OP_SLT   = 4'b0110;
   localparam logic [3:0] OP_MOVN  = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_XOR   = 4'b1001;
   localparam logic [3:0] OP_MFHI  = 4'b1110;
   localparam logic [3:0] OP_MFLO  = 4'b1111;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t               state;
   logic [SW-1:0]        cnt;
   logic [2*WIDTH-1:0]   work;      // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]     opb;       // multiplicand or divisor magnitude
   logic                 is_div;
   logic                 dz;        // divisor was zero
   logic                 neg_q;     // product / quotient must be negated
   logic                 neg_r;     // remainder takes the dividend's (negative) sign

   logic [WIDTH-1:0]     sum, dif;
   logic                 ovf_add, ovf_sub;
   logic                 is_muldiv, is_hilo_grp, sgn_op, accept;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum, div_tmp, div_dif;
   logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

   // Single-cycle arithmetic, overflow from the current-cycle sum/difference.
   assign sum     = a + b;
   assign dif     = a - b;
   assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

   // Opcode groups: 1010-1101 start the unit, 1010-1111 must wait for it.
   assign is_muldiv   = aluctr[3] & (aluctr[2] ^ aluctr[1]);
   assign is_hilo_grp = aluctr[3] & (aluctr[2] | aluctr[1]);
   assign sgn_op      = ~aluctr[0];
   assign stall       = in_valid & busy & is_hilo_grp;
   assign accept      = in_valid & is_muldiv & ~stall & (state == IDLE);

   // Result mux for the single-cycle ops; mul/div issue returns zero.
   always_comb begin
      // NOTE: default assignment first so no path leaves res unassigned (no latch).
      res = '0;
      case (aluctr)
         OP_ADD, OP_ADDU: res = sum;
         OP_SUB:          res = dif;
         OP_SLL:          res = b << a[SW-1:0];
         OP_OR:           res = a | b;
         OP_AND:          res = a & b;
         OP_SLT:          res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_MOVN:         res = a;
         OP_SLTU:         res = {{(WIDTH-1){1'b0}}, a < b};
         OP_XOR:          res = a ^ b;
         OP_MFHI:         res = hi;
         OP_MFLO:         res = lo;
         default:         res = '0;
      endcase
   end

   assign zero  = (res == '0);
   assign wrctr = in_valid & ~stall & ~is_muldiv
                & ~((aluctr == OP_ADD) & ovf_add)
                & ~((aluctr == OP_SUB) & ovf_sub)
                & ~((aluctr == OP_MOVN) & (b == '0));

   // Operand magnitudes and per-step datapath of the iterative unit.
   always_comb begin
      mag_a    = (sgn_op && a[WIDTH-1]) ? -a : a;
      mag_b    = (sgn_op && b[WIDTH-1]) ? -b : b;
      mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opb} : '0);
      mul_next = {mul_sum, work[WIDTH-1:1]};
      div_tmp  = work[2*WIDTH-1:WIDTH-1];
      div_dif  = div_tmp - {1'b0, opb};
      div_next = div_dif[WIDTH] ? {div_tmp[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                : {div_dif[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
   end

   // Sign fix-up applied in FIX; divide by zero forces an all-ones quotient.
   always_comb begin
      prod_fix = neg_q ? -work : work;
      quo      = work[WIDTH-1:0];
      rem      = work[2*WIDTH-1:WIDTH];
      if (is_div) begin
         fix_lo = dz ? '1 : (neg_q ? -quo : quo);
         fix_hi = neg_r ? -rem : rem;
      end else begin
         fix_lo = prod_fix[WIDTH-1:0];
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   // Mul/div sequencer: IDLE -> ITER (WIDTH steps) -> FIX -> IDLE.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         work   <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         dz     <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= ITER;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  is_div <= aluctr[2];
                  dz     <= (b == '0);
                  opb    <= mag_b;
                  work   <= {{WIDTH{1'b0}}, mag_a};
                  neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= sgn_op & a[WIDTH-1];
               end
            end
            ITER: begin
               work <= is_div ? div_next : mul_next;
               cnt  <= cnt + SW'(1);
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a WIDTH=32 instance for the main vectors and a
// WIDTH=8 instance for the narrow-datapath cases.
module tb_alu_muldiv;

   localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLL = 4'b0010, OR_ = 4'b0011;
   localparam logic [3:0] ADDU = 4'b0101, SLT = 4'b0110, MOVN = 4'b0111, SLTU = 4'b1000;
   localparam logic [3:0] XOR_ = 4'b1001, MULT = 4'b1010, MULTU = 4'b1011;
   localparam logic [3:0] DIV = 4'b1100, DIVU = 4'b1101, MFHI = 4'b1110, MFLO = 4'b1111;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid;
   logic [3:0]  aluctr;
   logic [31:0] a, b, res, hi, lo;
   logic        zero, wrctr, stall, busy, done;

   logic        in_valid8;
   logic [3:0]  aluctr8;
   logic [7:0]  a8, b8, res8, hi8, lo8;
   logic        zero8, wrctr8, stall8, busy8, done8;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int busy_total = 0;
   int acc_cyc, busy_mark;
   bit seen;

   alu_muldiv #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aluctr(aluctr), .a(a), .b(b),
      .res(res), .zero(zero), .wrctr(wrctr), .stall(stall), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   alu_muldiv #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .aluctr(aluctr8), .a(a8), .b(b8),
      .res(res8), .zero(zero8), .wrctr(wrctr8), .stall(stall8), .busy(busy8), .done(done8),
      .hi(hi8), .lo(lo8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (busy) busy_total++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
      in_valid = 1'b1;
      aluctr   = op;
      a        = va;
      b        = vb;
      #1;
   endtask

   // Issue a mul/div from IDLE and let edge T0 accept it.
   task automatic start(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
      drive(op, va, vb);
      check("issue_stall", stall, 0);
      check("issue_wrctr", wrctr, 0);
      check("issue_res", res, 0);
      tick();
      acc_cyc   = cyc;
      busy_mark = busy_total;
      in_valid  = 1'b0;
      check("busy_after_accept", busy, 1);
   endtask

   // Wait (bounded) for done, then check latency, busy span and HI/LO.
   task automatic finish_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      for (int n = 0; n < 100 && !done; n++) tick();
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, 64'(cyc - acc_cyc + 1), 34);
      check({tag, "_busy_cycles"}, 64'(busy_total - busy_mark), 33);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_hi"}, hi, ehi);
      check({tag, "_lo"}, lo, elo);
      tick();
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; aluctr = '0; a = '0; b = '0;
      in_valid8 = 1'b0; aluctr8 = '0; a8 = '0; b8 = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_hi8", hi8, 0);
      rst_n = 1'b1;
      tick();

      // Single-cycle ops
      drive(ADD, 32'h7FFF_FFFF, 32'h1);
      check("add_ovf_res", res, 32'h8000_0000);
      check("add_ovf_wrctr", wrctr, 0);
      drive(ADDU, 32'h7FFF_FFFF, 32'h1);
      check("addu_res", res, 32'h8000_0000);
      check("addu_wrctr", wrctr, 1);
      drive(SUB, 32'h8000_0000, 32'h1);
      check("sub_ovf_res", res, 32'h7FFF_FFFF);
      check("sub_ovf_wrctr", wrctr, 0);
      drive(SUB, 32'd5, 32'd5);
      check("sub_zero_res", res, 0);
      check("sub_zero_flag", zero, 1);
      check("sub_zero_wrctr", wrctr, 1);
      drive(ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("add_neg_res", res, 32'hFFFF_FFFE);
      check("add_neg_wrctr", wrctr, 1);
      drive(SLT, 32'hFFFF_FFFF, 32'h1);
      check("slt_res", res, 1);
      drive(SLTU, 32'hFFFF_FFFF, 32'h1);
      check("sltu_res", res, 0);
      check("sltu_zero", zero, 1);
      drive(XOR_, 32'hF0F0_1234, 32'h0FF0_FFFF);
      check("xor_res", res, 32'hFF00_EDCB);
      drive(OR_, 32'h0000_00F0, 32'h0000_000F);
      check("or_res", res, 32'h0000_00FF);
      drive(SLL, 32'h0000_0024, 32'h0000_0003);
      check("sll_res", res, 32'h0000_0030);
      drive(MOVN, 32'h1234_5678, 32'h0);
      check("movn_b0_wrctr", wrctr, 0);
      drive(MOVN, 32'h1234_5678, 32'h3);
      check("movn_res", res, 32'h1234_5678);
      check("movn_wrctr", wrctr, 1);
      in_valid = 1'b0;
      #1;
      check("invalid_wrctr", wrctr, 0);
      tick();

      // Signed mult with stall interplay while busy
      start(MULT, 32'hFFFF_FFFD, 32'd7);
      tick();
      drive(MFHI, 32'h0, 32'h0);
      check("mfhi_busy_stall", stall, 1);
      check("mfhi_busy_wrctr", wrctr, 0);
      drive(MULT, 32'd2, 32'd2);
      check("mult_busy_stall", stall, 1);
      check("mult_busy_wrctr", wrctr, 0);
      tick();
      drive(ADD, 32'd3, 32'd4);
      check("add_busy_stall", stall, 0);
      check("add_busy_res", res, 7);
      check("add_busy_wrctr", wrctr, 1);
      tick();
      in_valid = 1'b0;
      finish_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      drive(MFHI, 32'h0, 32'h0);
      check("mfhi_after_stall", stall, 0);
      check("mfhi_after_res", res, 32'hFFFF_FFFF);
      check("mfhi_after_wrctr", wrctr, 1);
      drive(MFLO, 32'h0, 32'h0);
      check("mflo_after_res", res, 32'hFFFF_FFEB);
      in_valid = 1'b0;
      tick();
      check("no_second_accept", busy, 0);

      start(MULTU, 32'hFFFF_FFFD, 32'd7);
      finish_op("multu", 32'h0000_0006, 32'hFFFF_FFEB);
      start(DIVU, 32'd100, 32'd7);
      finish_op("divu", 32'd2, 32'd14);
      start(DIV, 32'hFFFF_FFF9, 32'd2);
      finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start(DIV, 32'd5, 32'd0);
      finish_op("div_by0", 32'd5, 32'hFFFF_FFFF);
      start(DIV, 32'hFFFF_FFFA, 32'd0);
      finish_op("div_neg_by0", 32'hFFFF_FFFA, 32'hFFFF_FFFF);
      start(DIVU, 32'd9, 32'd0);
      finish_op("divu_by0", 32'd9, 32'hFFFF_FFFF);
      start(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("div_min", 32'h0, 32'h8000_0000);

      // Reset in the middle of a mult
      start(MULT, 32'd123, 32'd456);
      repeat (10) tick();
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done || hi != 0 || lo != 0) seen = 1'b1;
      end
      check("midrst_no_update", seen, 0);

      // WIDTH=8 instance
      in_valid8 = 1'b1; aluctr8 = SLL; a8 = 8'h09; b8 = 8'h01;
      #1;
      check("w8_sll_res", res8, 8'h02);
      check("w8_sll_wrctr", wrctr8, 1);
      aluctr8 = ADD; a8 = 8'h7F; b8 = 8'h01;
      #1;
      check("w8_add_ovf_wrctr", wrctr8, 0);
      aluctr8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
      #1;
      check("w8_issue_stall", stall8, 0);
      tick();
      acc_cyc   = cyc;
      in_valid8 = 1'b0;
      check("w8_busy", busy8, 1);
      for (int n = 0; n < 50 && !done8; n++) tick();
      check("w8_done", done8, 1);
      check("w8_latency", 64'(cyc - acc_cyc + 1), 10);
      check("w8_hi", hi8, 8'hFE);
      check("w8_lo", lo8, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
